// File: rtl/song_loader.sv
// UART song loader: packs received byte pairs (high byte first) into 16-bit words and writes them to SRAM.
// Optional trailing checksum verification is enabled by defining SONG_LOADER_CHECKSUM_EN.
module song_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [17:0] BASE_ADDR    = 18'h0ff00,
  parameter int          MAX_WORDS    = 256,
  parameter int          WE_CYCLES    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        UART_RX,
  input  logic        START,
  output logic        SRAM_WE,
  output logic        SRAM_CE,
  output logic        SRAM_OE,
  output logic        SRAM_LB,
  output logic        SRAM_UB,
  output logic [17:0] SRAM_A,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_DRIVE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [8:0]  WORD_COUNT
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int WE_W  = $clog2(WE_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [WE_W-1:0]  WE_LAST   = WE_W'(WE_CYCLES - 1);
  localparam logic [8:0]       MAX_CNT   = 9'(MAX_WORDS);

  generate
    if (WE_CYCLES < 1) begin : gWeCheck
      $error("song_loader: WE_CYCLES must be at least 1");
    end
    if (WE_CYCLES + 2 >= 10 * CLKS_PER_BIT) begin : gTimingCheck
      $error("song_loader: SRAM write must finish within one UART byte time");
    end
    if (CLKS_PER_BIT < 2 || MAX_WORDS < 1 || MAX_WORDS > 511) begin : gRangeCheck
      $error("song_loader: CLKS_PER_BIT or MAX_WORDS out of range");
    end
  endgenerate

  assign SRAM_OE = 1'b1;

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  rxState_t         rxState;
  logic             rxMeta, rxSync, rxPrev;
  logic [CNT_W-1:0] clkCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;
  logic             byteValid, frameErr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rxMeta    <= 1'b1;
      rxSync    <= 1'b1;
      rxPrev    <= 1'b1;
      rxState   <= RX_IDLE;
      clkCnt    <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      rxMeta    <= UART_RX;
      rxSync    <= rxMeta;
      rxPrev    <= rxSync;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
      case (rxState)
        RX_IDLE: begin
          clkCnt <= '0;
          if (rxPrev && !rxSync) rxState <= RX_START;
        end
        RX_START: begin
          if (clkCnt == HALF_LAST) begin
            clkCnt  <= '0;
            bitIdx  <= '0;
            rxState <= rxSync ? RX_IDLE : RX_DATA;
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clkCnt == BIT_LAST) begin
            clkCnt   <= '0;
            shiftReg <= {rxSync, shiftReg[7:1]};
            bitIdx   <= bitIdx + 1'b1;
            if (bitIdx == 3'd7) rxState <= RX_STOP;
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clkCnt == BIT_LAST) begin
            clkCnt    <= '0;
            byteValid <= rxSync;
            frameErr  <= !rxSync;
            rxState   <= RX_IDLE;
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Load / write FSM ----------------
  typedef enum logic [3:0] {
    IDLE, WAIT_HI, WAIT_LO, WR_SETUP, WR_PULSE, WR_HOLD, FINISH
`ifdef SONG_LOADER_CHECKSUM_EN
    , CK_HI, CK_LO
`endif
  } loadState_t;

  loadState_t      loadState;
  logic [7:0]      hiByte;
  logic [17:0]     addrReg;
  logic [WE_W-1:0] weCnt;
`ifdef SONG_LOADER_CHECKSUM_EN
  logic [15:0]     sumReg;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      loadState     <= IDLE;
      SRAM_WE       <= 1'b1;
      SRAM_CE       <= 1'b1;
      SRAM_LB       <= 1'b1;
      SRAM_UB       <= 1'b1;
      SRAM_A        <= BASE_ADDR;
      SRAM_DQ_OUT   <= '0;
      SRAM_DQ_DRIVE <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      ERR           <= 1'b0;
      WORD_COUNT    <= '0;
      hiByte        <= '0;
      addrReg       <= BASE_ADDR;
      weCnt         <= '0;
`ifdef SONG_LOADER_CHECKSUM_EN
      sumReg        <= '0;
`endif
    end else begin
      case (loadState)
        IDLE: begin
          // A byte arriving with START is dropped: only START is acted on here.
          if (START) begin
            loadState  <= WAIT_HI;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            WORD_COUNT <= '0;
            BUSY       <= 1'b1;
            SRAM_CE    <= 1'b0;
            SRAM_LB    <= 1'b0;
            SRAM_UB    <= 1'b0;
            addrReg    <= BASE_ADDR;
`ifdef SONG_LOADER_CHECKSUM_EN
            sumReg     <= '0;
`endif
          end
        end
        WAIT_HI: begin
          if (frameErr) begin
            ERR <= 1'b1;
            loadState <= FINISH;
            BUSY <= 1'b0; SRAM_CE <= 1'b1; SRAM_LB <= 1'b1; SRAM_UB <= 1'b1;
          end else if (byteValid) begin
            hiByte    <= shiftReg;
            loadState <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (frameErr) begin
            ERR <= 1'b1;
            loadState <= FINISH;
            BUSY <= 1'b0; SRAM_CE <= 1'b1; SRAM_LB <= 1'b1; SRAM_UB <= 1'b1;
          end else if (byteValid) begin
            // Address and data go out with the setup state so they lead WE by a cycle.
            SRAM_A        <= addrReg;
            SRAM_DQ_OUT   <= {hiByte, shiftReg};
            SRAM_DQ_DRIVE <= 1'b1;
            loadState     <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          SRAM_WE   <= 1'b0;
          weCnt     <= '0;
          loadState <= WR_PULSE;
        end
        WR_PULSE: begin
          if (weCnt == WE_LAST) begin
            SRAM_WE   <= 1'b1;
            loadState <= WR_HOLD;
          end else begin
            weCnt <= weCnt + 1'b1;
          end
        end
        WR_HOLD: begin
          WORD_COUNT    <= WORD_COUNT + 9'd1;
          addrReg       <= addrReg + 18'd1;
          SRAM_DQ_DRIVE <= 1'b0;
`ifdef SONG_LOADER_CHECKSUM_EN
          sumReg        <= sumReg + SRAM_DQ_OUT;
`endif
          if (SRAM_DQ_OUT[15:12] == 4'b0000) begin
`ifdef SONG_LOADER_CHECKSUM_EN
            loadState <= CK_HI;
`else
            DONE <= 1'b1;
            loadState <= FINISH;
            BUSY <= 1'b0; SRAM_CE <= 1'b1; SRAM_LB <= 1'b1; SRAM_UB <= 1'b1;
`endif
          end else if (WORD_COUNT + 9'd1 == MAX_CNT) begin
            ERR <= 1'b1;
            loadState <= FINISH;
            BUSY <= 1'b0; SRAM_CE <= 1'b1; SRAM_LB <= 1'b1; SRAM_UB <= 1'b1;
          end else begin
            loadState <= WAIT_HI;
          end
        end
`ifdef SONG_LOADER_CHECKSUM_EN
        CK_HI: begin
          if (frameErr) begin
            ERR <= 1'b1;
            loadState <= FINISH;
            BUSY <= 1'b0; SRAM_CE <= 1'b1; SRAM_LB <= 1'b1; SRAM_UB <= 1'b1;
          end else if (byteValid) begin
            hiByte    <= shiftReg;
            loadState <= CK_LO;
          end
        end
        CK_LO: begin
          if (frameErr || (byteValid && {hiByte, shiftReg} != sumReg)) begin
            ERR <= 1'b1;
            loadState <= FINISH;
            BUSY <= 1'b0; SRAM_CE <= 1'b1; SRAM_LB <= 1'b1; SRAM_UB <= 1'b1;
          end else if (byteValid) begin
            DONE <= 1'b1;
            loadState <= FINISH;
            BUSY <= 1'b0; SRAM_CE <= 1'b1; SRAM_LB <= 1'b1; SRAM_UB <= 1'b1;
          end
        end
`endif
        FINISH: loadState <= IDLE;
        default: loadState <= IDLE;
      endcase
    end
  end

endmodule
